// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

   // Arbiter control states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Default requester count and matching index width
   localparam int N_DEF = 4;
   localparam int IW    = $clog2(N_DEF);

   // Upper bound on one-hot width handled by onehot2idx
   localparam int OH_MAX_W  = 32;
   localparam int IDX_MAX_W = 5;

   // Encode a one-hot (or zero) vector to its bit index; zero maps to 0
   function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [OH_MAX_W-1:0] oh);
      logic [IDX_MAX_W-1:0] idx;
      idx = {IDX_MAX_W{1'b0}};
      for (int i = 0; i < OH_MAX_W; i++) begin
         if (oh[i]) begin
            idx = idx | IDX_MAX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/lowest_one_select.sv
// Isolates the lowest set bit of a vector (all-zero in, all-zero out).
module lowest_one_select #(
   parameter int N = 4
) (
   input  logic [N-1:0] I,
   output logic [N-1:0] O
);

   // Two's-complement trick: I-1 flips the lowest one and everything below it
   assign O = I & ~(I - N'(1));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer, registered one-hot grant
// held until release, optional hold timeout.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int CW       = 8
) (
   input  logic                 CLK,
   input  logic                 ASYNCRESETN,
   input  logic [N-1:0]         REQ,
   input  logic                 DONE,
   output logic [N-1:0]         GNT,
   output logic                 VALID,
   output logic [$clog2(N)-1:0] GNT_IDX
);

   localparam int IDXW = $clog2(N);
   // Last count value before a forced release (unused when MAX_HOLD is 0)
   localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? {CW{1'b0}} : CW'(MAX_HOLD - 1);

   state_e            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              valid_q, valid_d;

   logic [N-1:0]      mask_s;
   logic [N-1:0]      masked_s;
   logic [N-1:0]      masked_win_s;
   logic [N-1:0]      req_win_s;
   logic [N-1:0]      win_oh_s;
   logic [IDXW-1:0]   win_idx_s;
   logic [IDXW-1:0]   win_next_ptr_s;
   logic              timeout_s;
   logic              release_s;

   // Requesters at or above the pointer keep priority; lower ones wait for wrap
   assign mask_s   = ~((N'(1) << ptr_q) - N'(1));
   assign masked_s = REQ & mask_s;

   lowest_one_select #(.N(N)) u_sel_masked (
      .I (masked_s),
      .O (masked_win_s)
   );

   lowest_one_select #(.N(N)) u_sel_req (
      .I (REQ),
      .O (req_win_s)
   );

   assign win_oh_s       = (|masked_s) ? masked_win_s : req_win_s;
   assign win_idx_s      = IDXW'(onehot2idx(OH_MAX_W'(win_oh_s)));
   assign win_next_ptr_s = (win_idx_s == IDXW'(N - 1)) ? {IDXW{1'b0}} : (win_idx_s + IDXW'(1));

   assign timeout_s = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
   // Grantee releases on DONE, on dropping its request, or when the hold expires
   assign release_s = DONE | ~(|(REQ & gnt_q)) | timeout_s;

   // Next-state, grant, pointer and hold-count logic
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               state_d = HOLD;
               gnt_d   = win_oh_s;
               ptr_d   = win_next_ptr_s;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (release_s) begin
               if (|REQ) begin
                  // Back-to-back handover; pointer already moved past the old grantee
                  state_d = HOLD;
                  gnt_d   = win_oh_s;
                  ptr_d   = win_next_ptr_s;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  state_d = IDLE;
                  gnt_d   = {N{1'b0}};
                  cnt_d   = {CW{1'b0}};
               end
            end else begin
               if (cnt_q != {CW{1'b1}}) begin
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = {N{1'b0}};
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // Output decode computed from the next grant so outputs stay registered
   always_comb begin
      valid_d = |gnt_d;
      idx_d   = IDXW'(onehot2idx(OH_MAX_W'(gnt_d)));
   end

   // State, pointer, counter and output registers
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= IDLE;
         gnt_q   <= {N{1'b0}};
         ptr_q   <= {IDXW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         idx_q   <= {IDXW{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign GNT     = gnt_q;
   assign VALID   = valid_q;
   assign GNT_IDX = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomised bench for rr_arbiter with a rotating-search reference model,
// plus directed sequences with literal expectations.
module tb_rr_arbiter;

   logic       CLK = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       done;

   logic [3:0] gnt0, gnt3;
   logic       valid0, valid3;
   logic [1:0] idx0, idx3;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   rr_arbiter #(.N(4), .MAX_HOLD(0), .CW(8)) dut0 (
      .CLK(CLK), .ASYNCRESETN(rst_n), .REQ(req), .DONE(done),
      .GNT(gnt0), .VALID(valid0), .GNT_IDX(idx0)
   );

   rr_arbiter #(.N(4), .MAX_HOLD(3), .CW(8)) dut3 (
      .CLK(CLK), .ASYNCRESETN(rst_n), .REQ(req), .DONE(done),
      .GNT(gnt3), .VALID(valid3), .GNT_IDX(idx3)
   );

   // Reference model: who owns the resource, where the search starts, cycles held
   typedef struct packed {
      int owner;
      int ptr;
      int held;
   } mstate_t;

   mstate_t m0 = '{owner: -1, ptr: 0, held: 0};
   mstate_t m3 = '{owner: -1, ptr: 0, held: 0};

   function automatic mstate_t mstep(mstate_t s, logic [3:0] r, logic d, int maxhold);
      mstate_t n;
      bit rel;
      int w;
      n = s;
      if (s.owner < 0) rel = 1'b1;
      else rel = d || !r[s.owner] || (maxhold != 0 && s.held >= maxhold);
      if (!rel) begin
         n.held = s.held + 1;
         return n;
      end
      if (r == 4'b0000) begin
         n.owner = -1;
         n.held  = 0;
         return n;
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
         if (w < 0 && r[(s.ptr + k) % 4]) w = (s.ptr + k) % 4;
      end
      n.owner = w;
      n.ptr   = (w + 1) % 4;
      n.held  = 1;
      return n;
   endfunction

   function automatic logic [3:0] exp_gnt(int owner);
      logic [3:0] g;
      g = 4'b0000;
      if (owner >= 0) g[owner] = 1'b1;
      return g;
   endfunction

   // Advance the reference model on each edge, reset with the DUT
   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= '{owner: -1, ptr: 0, held: 0};
         m3 <= '{owner: -1, ptr: 0, held: 0};
      end else begin
         m0 <= mstep(m0, req, done, 0);
         m3 <= mstep(m3, req, done, 3);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model on the falling edge
   always @(negedge CLK) begin
      check("gnt0",   32'(gnt0),   32'(exp_gnt(m0.owner)));
      check("valid0", 32'(valid0), 32'(m0.owner >= 0));
      check("idx0",   32'(idx0),   (m0.owner >= 0) ? 32'(m0.owner) : 32'd0);
      check("gnt3",   32'(gnt3),   32'(exp_gnt(m3.owner)));
      check("valid3", 32'(valid3), 32'(m3.owner >= 0));
      check("idx3",   32'(idx3),   (m3.owner >= 0) ? 32'(m3.owner) : 32'd0);
   end

   task automatic step(input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [3:0] rr;

   initial begin
      // Reset holds grants off even with every requester active
      rst_n = 1'b0;
      req   = 4'hF;
      done  = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_gnt",   32'(gnt0),   32'h0);
      check("rst_valid", 32'(valid0), 32'h0);
      check("rst_idx",   32'(idx0),   32'h0);
      rst_n = 1'b1;

      // Single request, hold, then release
      step(4'b0100, 1'b0);
      check("single_gnt", 32'(gnt0), 32'h4);
      check("single_idx", 32'(idx0), 32'd2);
      step(4'b0100, 1'b0);
      check("single_hold", 32'(gnt0), 32'h4);
      step(4'b0000, 1'b1);
      check("single_rel", 32'(gnt0), 32'h0);
      check("single_rel_valid", 32'(valid0), 32'h0);

      // Rotation with DONE every second cycle
      reset_pulse();
      for (int g = 0; g <= 4; g++) begin
         step(4'hF, (g > 0) ? 1'b1 : 1'b0);
         check("rot_idx", 32'(idx0), 32'(g % 4));
         check("rot_valid", 32'(valid0), 32'h1);
         if (g < 4) begin
            step(4'hF, 1'b0);
            check("rot_hold", 32'(idx0), 32'(g % 4));
         end
      end

      // Priority skip: grant to 1 leaves pointer at 2, then only 0 and 1 request
      step(4'hF, 1'b1);
      check("skip_pre", 32'(gnt0), 32'h2);
      step(4'b0011, 1'b1);
      check("skip_gnt", 32'(gnt0), 32'h1);
      step(4'b0011, 1'b1);
      check("skip_ptr", 32'(gnt0), 32'h2);
      step(4'b0000, 1'b1);

      // Hold timeout of three cycles
      reset_pulse();
      for (int i = 0; i < 9; i++) begin
         step(4'b0011, 1'b0);
         check("tmo_gnt3", 32'(gnt3), (i < 3 || i >= 6) ? 32'h1 : 32'h2);
         check("tmo_gnt0", 32'(gnt0), 32'h1);
      end

      // Grantee drops its request
      step(4'b0010, 1'b0);
      check("drop_gnt0", 32'(gnt0), 32'h2);
      check("drop_gnt3", 32'(gnt3), 32'h2);

      // Asynchronous reset in the middle of a grant
      #2;
      rst_n = 1'b0;
      #1;
      check("async_gnt0",  32'(gnt0),   32'h0);
      check("async_gnt3",  32'(gnt3),   32'h0);
      check("async_valid", 32'(valid0), 32'h0);
      check("async_idx",   32'(idx0),   32'h0);
      @(posedge CLK);
      #1;
      rst_n = 1'b1;
      step(4'b1000, 1'b0);
      check("post_rst_gnt", 32'(gnt0), 32'h8);
      check("post_rst_idx", 32'(idx0), 32'd3);

      // Random traffic, occasionally holding the request vector and resetting
      rr = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 1) == 0) rr = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         step(rr, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end

      @(negedge CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
